// File: rtl/logic_op_pkg.sv
// Opcode encoding and the bitwise evaluation function shared by the logic pipe.
package logic_op_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_XNOR = 3'd5,
    OP_ANDN = 3'd6,
    OP_PASS = 3'd7
  } logic_op_t;

  // Callers zero-extend operands to this width and truncate the result to their
  // own WIDTH; operand widths above this bound are not supported.
  localparam int unsigned LOGIC_MAX_W = 1024;

  function automatic logic [LOGIC_MAX_W-1:0] logic_eval(
    input logic_op_t              op,
    input logic [LOGIC_MAX_W-1:0] a,
    input logic [LOGIC_MAX_W-1:0] b
  );
    case (op)
      OP_AND:  logic_eval = a & b;
      OP_OR:   logic_eval = a | b;
      OP_XOR:  logic_eval = a ^ b;
      OP_NOR:  logic_eval = ~(a | b);
      OP_NAND: logic_eval = ~(a & b);
      OP_XNOR: logic_eval = ~(a ^ b);
      OP_ANDN: logic_eval = a & ~b;
      default: logic_eval = a;
    endcase
  endfunction

endpackage

// File: rtl/logic_stage.sv
// One pipeline register of the logic pipe: {valid, data, tag, zero} with load/clear.
module logic_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  input  logic [TAG_W-1:0] d_tag,
  input  logic             d_zero,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [TAG_W-1:0] tag,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= d_valid;
    end
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load && d_valid) begin
      data <= d_data;
      tag  <= d_tag;
      zero <= d_zero;
    end
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise logic unit: eight logic functions, STAGES registers with
// valid/ready flow control, tag sidecar, zero flag and flush.
module bitwise_logic_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic_op_t                     in_op,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_zero,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] can_load;
  logic [STAGES-1:0] move;
  logic [WIDTH-1:0]  s_data [STAGES];
  logic [TAG_W-1:0]  s_tag  [STAGES];
  logic [STAGES-1:0] s_zero;

  logic [WIDTH-1:0]  res;
  logic              res_zero;

  always_comb begin
    res      = WIDTH'(logic_eval(in_op, LOGIC_MAX_W'(in_a), LOGIC_MAX_W'(in_b)));
    res_zero = (res == '0);
  end

  // Ready ripples from the output stage backwards so bubbles collapse.
  always_comb begin
    move               = '0;
    can_load           = '0;
    move[STAGES-1]     = v[STAGES-1] && out_ready;
    can_load[STAGES-1] = !v[STAGES-1] || move[STAGES-1];
    for (int unsigned k = 1; k < STAGES; k++) begin
      move[STAGES-1-k]     = v[STAGES-1-k] && can_load[STAGES-k];
      can_load[STAGES-1-k] = !v[STAGES-1-k] || move[STAGES-1-k];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             dv;
    logic [WIDTH-1:0] dd;
    logic [TAG_W-1:0] dt;
    logic             dz;

    if (i == 0) begin : g_head
      assign dv = in_valid;
      assign dd = res;
      assign dt = in_tag;
      assign dz = res_zero;
    end else begin : g_body
      assign dv = v[i-1];
      assign dd = s_data[i-1];
      assign dt = s_tag[i-1];
      assign dz = s_zero[i-1];
    end

    logic_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .load    (can_load[i]),
      .clear   (flush),
      .d_valid (dv),
      .d_data  (dd),
      .d_tag   (dt),
      .d_zero  (dz),
      .valid   (v[i]),
      .data    (s_data[i]),
      .tag     (s_tag[i]),
      .zero    (s_zero[i])
    );
  end

  always_comb begin
    in_ready  = can_load[0];
    out_valid = v[STAGES-1];
    out_data  = out_valid ? s_data[STAGES-1] : '0;
    out_tag   = out_valid ? s_tag[STAGES-1]  : '0;
    out_zero  = out_valid && s_zero[STAGES-1];
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

endmodule
